// File: rtl/mem_wb_stage_pkg.sv
// Shared opcode and register constants for the memory/writeback stage and the decoders
// that identify load, store and register-writing instructions.
package mem_wb_stage_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Opcode field of an instruction word.
  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/mem_wb_stage_dffe.sv
// Pipeline latch cell: enable flop with synchronous reset and a synchronous clear.
// Reset beats clear, clear beats enable, so a flush wins over a stall.
module mem_wb_stage_dffe #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Register with reset > clear > enable priority.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_wb_stage_insn_dest_decode.sv
// Destination decode: flags loads/stores and resolves which register, if any, an
// instruction writes. Shared with the decode stage's hazard detection.
module insn_dest_decode
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        is_lw_o,
  output logic        is_sw_o,
  output logic        writes_rd_o,
  output logic [4:0]  rd_o
);

  logic [4:0] op;
  logic       unused_low_bits;

  assign op              = insn_opcode(insn_i);
  assign unused_low_bits = ^insn_i[21:0];

  // Classify opcode; non-writers report rd = 0.
  always_comb begin
    is_lw_o     = 1'b0;
    is_sw_o     = 1'b0;
    writes_rd_o = 1'b0;
    rd_o        = 5'd0;
    case (op)
      OP_ALU, OP_ADDI: begin
        writes_rd_o = 1'b1;
        rd_o        = insn_i[26:22];
      end
      OP_LW: begin
        is_lw_o     = 1'b1;
        writes_rd_o = 1'b1;
        rd_o        = insn_i[26:22];
      end
      OP_SW: begin
        is_sw_o = 1'b1;
      end
      OP_JAL: begin
        writes_rd_o = 1'b1;
        rd_o        = REG_RA;
      end
      OP_SETX: begin
        writes_rd_o = 1'b1;
        rd_o        = REG_RSTATUS;
      end
      default: begin
        writes_rd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage plus M/W pipeline latch. Drives the synchronous-read dmem directly from
// the M inputs, latches results for writeback, and captures load data into a hold
// register on the first stalled edge so d_out stays put while dmem keeps re-reading.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [31:0]       insn_in,
  input  logic [DATA_W-1:0] o_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output logic              valid_out,
  output logic [31:0]       insn_out,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] d_out,
  output logic              rf_we_out,
  output logic [4:0]        rd_out,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  // M-stage decode
  logic       unused_m_is_lw;
  logic       m_is_sw;
  logic       m_writes;
  logic [4:0] m_rd;
  logic       rf_we_d;

  insn_dest_decode u_m_dec (
    .insn_i      (insn_in),
    .is_lw_o     (unused_m_is_lw),
    .is_sw_o     (m_is_sw),
    .writes_rd_o (m_writes),
    .rd_o        (m_rd)
  );

  assign address_dmem = o_in[ADDR_W-1:0];
  assign data         = b_in;
  assign wren         = valid_in & m_is_sw & ~stall & ~flush & ~reset;
  assign rf_we_d      = valid_in & m_writes & (m_rd != 5'd0);

  // M/W latch fields
  logic              valid_q;
  logic [31:0]       insn_q;
  logic              we_q;
  logic [DATA_W-1:0] o_q;
  logic [4:0]        rd_q;
  logic              adv_en;
  logic              data_en;

  assign adv_en  = ~stall;
  assign data_en = ~stall & ~flush;

  mem_wb_stage_dffe #(.W(1)) u_valid (
    .clk_i(clock), .rst_i(reset), .clr_i(flush), .en_i(adv_en), .d_i(valid_in), .q_o(valid_q)
  );
  mem_wb_stage_dffe #(.W(32)) u_insn (
    .clk_i(clock), .rst_i(reset), .clr_i(flush), .en_i(adv_en), .d_i(insn_in), .q_o(insn_q)
  );
  mem_wb_stage_dffe #(.W(1)) u_we (
    .clk_i(clock), .rst_i(reset), .clr_i(flush), .en_i(adv_en), .d_i(rf_we_d), .q_o(we_q)
  );
  mem_wb_stage_dffe #(.W(DATA_W)) u_o (
    .clk_i(clock), .rst_i(reset), .clr_i(1'b0), .en_i(data_en), .d_i(o_in), .q_o(o_q)
  );
  mem_wb_stage_dffe #(.W(5)) u_rd (
    .clk_i(clock), .rst_i(reset), .clr_i(1'b0), .en_i(data_en), .d_i(m_rd), .q_o(rd_q)
  );

  // W-stage decode
  logic       w_is_lw;
  logic       unused_w_is_sw;
  logic       unused_w_writes;
  logic [4:0] unused_w_rd;

  insn_dest_decode u_w_dec (
    .insn_i      (insn_q),
    .is_lw_o     (w_is_lw),
    .is_sw_o     (unused_w_is_sw),
    .writes_rd_o (unused_w_writes),
    .rd_o        (unused_w_rd)
  );

  // Load hold
  logic              hold_vld_q;
  logic              hold_vld_d;
  logic              capture;
  logic [DATA_W-1:0] hold_q;

  // Capture on the first stalled edge with a real load in W; drop the hold on advance.
  always_comb begin
    capture    = stall & ~flush & valid_q & w_is_lw & ~hold_vld_q;
    hold_vld_d = stall & (hold_vld_q | capture);
  end

  mem_wb_stage_dffe #(.W(DATA_W)) u_hold (
    .clk_i(clock), .rst_i(reset), .clr_i(1'b0), .en_i(capture), .d_i(q_dmem), .q_o(hold_q)
  );
  mem_wb_stage_dffe #(.W(1)) u_hold_vld (
    .clk_i(clock), .rst_i(reset), .clr_i(flush), .en_i(1'b1), .d_i(hold_vld_d), .q_o(hold_vld_q)
  );

  // W outputs and bypass
  assign valid_out = valid_q;
  assign insn_out  = insn_q;
  assign o_out     = o_q;
  assign rd_out    = rd_q;
  assign rf_we_out = we_q;
  assign d_out     = hold_vld_q ? hold_q : q_dmem;
  assign fwd_valid = we_q & (rd_q != 5'd0);
  assign fwd_data  = w_is_lw ? d_out : o_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a transaction-level reference model and a
// write-before-read synchronous dmem.
module tb_mem_wb_stage;

  localparam int AW = 12;
  localparam int DW = 32;

  localparam logic [4:0] T_ALU  = 5'b00000;
  localparam logic [4:0] T_ADDI = 5'b00101;
  localparam logic [4:0] T_SW   = 5'b00111;
  localparam logic [4:0] T_LW   = 5'b01000;
  localparam logic [4:0] T_JAL  = 5'b00011;
  localparam logic [4:0] T_SETX = 5'b10101;

  logic          clock = 1'b0;
  logic          reset, stall, flush, valid_in;
  logic [31:0]   insn_in;
  logic [DW-1:0] o_in, b_in, q_dmem;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data, o_out, d_out, fwd_data;
  logic          wren, valid_out, rf_we_out, fwd_valid;
  logic [31:0]   insn_out;
  logic [4:0]    rd_out;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .insn_in(insn_in), .o_in(o_in), .b_in(b_in), .address_dmem(address_dmem),
    .data(data), .wren(wren), .q_dmem(q_dmem), .valid_out(valid_out),
    .insn_out(insn_out), .o_out(o_out), .d_out(d_out), .rf_we_out(rf_we_out),
    .rd_out(rd_out), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  always #5 clock = ~clock;

  // Environment dmem: write lands first, read of the same edge sees it.
  logic [DW-1:0] dmem [4096];
  always @(posedge clock) begin
    if (wren) dmem[address_dmem] = data;
    q_dmem <= dmem[address_dmem];
  end

  // Reference model state
  logic [DW-1:0] rmem [4096];
  logic          m_valid, m_we, m_rst;
  logic [31:0]   m_insn;
  logic [DW-1:0] m_o, m_d;
  logic [4:0]    m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_rd(input logic [31:0] insn);
    case (insn[31:27])
      T_ALU, T_ADDI, T_LW: return insn[26:22];
      T_JAL:               return 5'd31;
      T_SETX:              return 5'd30;
      default:             return 5'd0;
    endcase
  endfunction

  function automatic bit ref_writes(input logic [31:0] insn);
    return insn[31:27] inside {T_ALU, T_ADDI, T_LW, T_JAL, T_SETX};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'($urandom)};
  endfunction

  // One cycle: apply M inputs, check the dmem drive, clock, update model, check W outputs.
  task automatic step(input logic r, s, f, v, input logic [31:0] ins,
                      input logic [DW-1:0] o, input logic [DW-1:0] b);
    logic exp_wren;
    logic is_lw_w;
    reset = r; stall = s; flush = f; valid_in = v; insn_in = ins; o_in = o; b_in = b;
    #2;
    exp_wren = v && ins[31:27] == T_SW && !s && !f && !r;
    chk("addr", 32'(address_dmem), 32'(o[AW-1:0]));
    chk("wdata", data, b);
    chk("wren", 32'(wren), 32'(exp_wren));
    @(posedge clock);
    if (r) begin
      m_valid = 0; m_insn = 0; m_o = 0; m_rd = 0; m_we = 0; m_rst = 1;
    end else if (f) begin
      m_valid = 0; m_insn = 0; m_we = 0; m_rst = 0;
    end else if (!s) begin
      if (exp_wren) rmem[o[AW-1:0]] = b;
      m_valid = v; m_insn = ins; m_o = o; m_rd = ref_rd(ins);
      m_we = v && ref_writes(ins) && m_rd != 5'd0;
      if (ins[31:27] == T_LW) m_d = rmem[o[AW-1:0]];
      m_rst = 0;
    end
    #1;
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("insn_out", insn_out, m_insn);
    chk("rf_we_out", 32'(rf_we_out), 32'(m_we));
    chk("fwd_valid", 32'(fwd_valid), 32'(m_we && m_rd != 5'd0));
    if (m_valid || m_rst) begin
      chk("o_out", o_out, m_o);
      chk("rd_out", 32'(rd_out), 32'(m_rd));
    end
    is_lw_w = m_insn[31:27] == T_LW;
    if (m_valid && is_lw_w) begin
      chk("d_out", d_out, m_d);
      chk("fwd_data_lw", fwd_data, m_d);
    end else if (m_valid || m_rst) begin
      chk("fwd_data", fwd_data, m_o);
    end
  endtask

  initial begin
    logic [4:0] op;
    logic [31:0] ins;
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = $urandom;
      rmem[i] = dmem[i];
    end
    dmem[16] = 32'd9; rmem[16] = 32'd9;
    m_valid = 0; m_insn = 0; m_o = 0; m_rd = 0; m_we = 0; m_d = 0; m_rst = 0;
    reset = 1; stall = 0; flush = 0; valid_in = 0; insn_in = 0; o_in = 0; b_in = 0;
    @(negedge clock);

    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid_out), 0);
    step(1, 0, 0, 1, mk(T_LW, 5'd2), 32'h4, 0);

    step(0, 0, 0, 1, mk(T_ADDI, 5'd3), 32'd5, 0);
    chk("addi_rd", 32'(rd_out), 3);
    chk("addi_fwd", fwd_data, 5);
    step(0, 0, 0, 1, mk(T_SW, 5'd1), 32'h0000_1004, 32'd7);
    chk("sw_no_we", 32'(rf_we_out), 0);
    step(0, 0, 0, 1, mk(T_LW, 5'd4), 32'h0000_0004, 0);
    chk("lw_d", d_out, 7);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1, mk(T_SW, 5'd0), 32'h0000_0010, 32'h55);
      chk("stall_hold_d", d_out, 7);
    end
    step(0, 0, 0, 1, mk(T_LW, 5'd5), 32'h0000_0010, 0);
    chk("lw_after_stall", d_out, 9);
    step(0, 1, 1, 1, mk(T_ADDI, 5'd6), 32'd1, 0);
    chk("flush_stall_valid", 32'(valid_out), 0);
    step(0, 0, 0, 1, mk(T_ALU, 5'd0), 32'd3, 0);
    chk("rd0_we", 32'(rf_we_out), 0);
    step(0, 0, 0, 1, mk(T_JAL, 5'd4), 32'h40, 0);
    chk("jal_rd", 32'(rd_out), 31);
    step(0, 0, 0, 1, mk(T_SETX, 5'd4), 32'h1, 0);
    chk("setx_rd", 32'(rd_out), 30);
    step(0, 0, 0, 1, mk(T_LW, 5'd8), 32'h0000_0004, 0);
    step(0, 1, 0, 1, mk(T_ADDI, 5'd9), 32'd2, 0);
    step(1, 1, 0, 1, mk(T_ADDI, 5'd9), 32'd2, 0);
    chk("rst_mid_o", o_out, 0);
    step(0, 0, 0, 1, mk(T_ADDI, 5'd7), 32'd11, 0);
    chk("post_rst_fwd", fwd_data, 11);

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0: op = T_ALU;
        1: op = T_ADDI;
        2: op = T_SW;
        3: op = T_LW;
        4: op = T_JAL;
        5: op = T_SETX;
        default: op = 5'($urandom);
      endcase
      ins = mk(op, 5'($urandom_range(0, 31)));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
           ins, $urandom & 32'hFFFF_F00F, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
